// File: rtl/cipher_seq_pkg.sv
// Shared definitions for the cipher sequencing controller: state encoding,
// default round/timeout parameters and the round-index width.
// Optional build macro affecting users of this package: CTRL_TIMEOUT_EN.
package cipher_seq_pkg;

    localparam int ROUNDS_DEF       = 32;
    localparam int LOAD_TIMEOUT_DEF = 31;
    localparam int IDX_W            = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_REQ  = 3'd1,
        ST_WAIT_LOAD = 3'd2,
        ST_INIT      = 3'd3,
        ST_RUN       = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

endpackage

// File: rtl/cipher_seq_wdog.sv
// Load watchdog: counts consecutive enabled cycles and raises a terminal-count
// flag on the LIMIT-th one. Only compiled when CTRL_TIMEOUT_EN is defined,
// since the controller instantiates it only in that build.
`ifdef CTRL_TIMEOUT_EN
module cipher_seq_wdog
    import cipher_seq_pkg::*;
#(
    parameter int LIMIT = LOAD_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = 8;
    // count_q holds the number of enabled cycles already completed, so the
    // LIMIT-th enabled cycle is the one that sees LIMIT-1.
    localparam logic [CNT_W-1:0] TERM = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise advance while enabled and saturate at TERM.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != TERM)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = en_i && (count_q == TERM);

endmodule
`endif

// File: rtl/cipher_seq_ctrl.sv
// Cipher block sequencer: requests input capture, initialises the core, steps
// it through ROUNDS rounds and holds the result valid until accepted.
// Moore machine: every output is decoded from registered state/counters.
// Build macro CTRL_TIMEOUT_EN adds a WAIT_LOAD watchdog and the sticky err flag;
// without it WAIT_LOAD waits forever and err is constant 0.
module cipher_seq_ctrl
    import cipher_seq_pkg::*;
#(
    parameter int ROUNDS       = ROUNDS_DEF,
    parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             abort,
    input  logic             load_done,
    input  logic             out_ready,
    output logic             load_start,
    output logic             core_init,
    output logic             round_en,
    output logic [IDX_W-1:0] round_idx,
    output logic             busy,
    output logic             out_valid,
    output logic             err
);

    // Reject out-of-range configurations at elaboration.
    if ((ROUNDS < 2) || (ROUNDS > 63) || (LOAD_TIMEOUT < 1) || (LOAD_TIMEOUT > 255)) begin : g_bad_cfg
        $error("cipher_seq_ctrl: ROUNDS must be 2..63 and LOAD_TIMEOUT 1..255");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

`ifdef CTRL_TIMEOUT_EN
    logic wdog_tc;
    logic err_q;
    logic err_d;

    // The watchdog only runs while waiting for the capture unit and restarts
    // from zero on every other cycle, so each WAIT_LOAD visit is timed afresh.
    cipher_seq_wdog #(
        .LIMIT (LOAD_TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_q != ST_WAIT_LOAD),
        .en_i    (state_q == ST_WAIT_LOAD),
        .tc_o    (wdog_tc)
    );
`endif

    // State and round-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and next round count; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        // The counter is only non-zero inside RUN, which keeps round_idx and
        // the terminal compare trivially bounded by ROUNDS-1.
        cnt_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) state_d = ST_LOAD_REQ;
            end
            ST_LOAD_REQ: begin
                state_d = ST_WAIT_LOAD;
            end
            ST_WAIT_LOAD: begin
                // load_done is only looked at here, so the second cycle of a
                // two-cycle done pulse (seen in INIT) has no effect.
                if (load_done) state_d = ST_INIT;
`ifdef CTRL_TIMEOUT_EN
                else if (wdog_tc) state_d = ST_IDLE;
`endif
            end
            ST_INIT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

`ifdef CTRL_TIMEOUT_EN
    // Sticky timeout flag: set when the watchdog forces WAIT_LOAD back to
    // IDLE, cleared as the next block enters LOAD_REQ.
    always_comb begin
        err_d = err_q;
        if ((state_q == ST_WAIT_LOAD) && !load_done && wdog_tc && !abort) begin
            err_d = 1'b1;
        end
        if (state_d == ST_LOAD_REQ) begin
            err_d = 1'b0;
        end
    end

    // Timeout flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Output decode from the registered state and counter only.
    always_comb begin
        load_start = 1'b0;
        core_init  = 1'b0;
        round_en   = 1'b0;
        round_idx  = '0;
        out_valid  = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_LOAD_REQ: load_start = 1'b1;
            ST_INIT:     core_init  = 1'b1;
            ST_RUN: begin
                round_en  = 1'b1;
                round_idx = cnt_q;
            end
            ST_DONE:     out_valid  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cipher_seq_ctrl.sv
// Scoreboard bench for cipher_seq_ctrl. For each block the driver works out,
// from the timing rules, the cycle of every visible event (busy edges,
// load_start, core_init, each round index, each out_valid cycle, err edges)
// and queues them; a monitor on the falling edge pops and compares every event
// the DUT actually shows.
module tb_cipher_seq_ctrl;

    localparam int ROUNDS       = 32;
    localparam int LOAD_TIMEOUT = 31;

    localparam int K_BF = 0;
    localparam int K_BR = 1;
    localparam int K_LS = 2;
    localparam int K_CI = 3;
    localparam int K_RD = 4;
    localparam int K_OV = 5;
    localparam int K_ER = 6;
    localparam int K_EF = 7;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       req       = 1'b0;
    logic       abort     = 1'b0;
    logic       load_done = 1'b0;
    logic       out_ready = 1'b0;
    logic       load_start;
    logic       core_init;
    logic       round_en;
    logic [5:0] round_idx;
    logic       busy;
    logic       out_valid;
    logic       err;

    bit mon_en    = 1'b0;
    bit busy_prev = 1'b0;
    bit err_prev  = 1'b0;
    bit err_exp   = 1'b0;

    cipher_seq_ctrl #(
        .ROUNDS       (ROUNDS),
        .LOAD_TIMEOUT (LOAD_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .abort      (abort),
        .load_done  (load_done),
        .out_ready  (out_ready),
        .load_start (load_start),
        .core_init  (core_init),
        .round_en   (round_en),
        .round_idx  (round_idx),
        .busy       (busy),
        .out_valid  (out_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Cycle c is the interval after the c-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            K_BF:    return "busy_fall";
            K_BR:    return "busy_rise";
            K_LS:    return "load_start";
            K_CI:    return "core_init";
            K_RD:    return "round";
            K_OV:    return "out_valid";
            K_ER:    return "err_rise";
            K_EF:    return "err_fall";
            default: return "none";
        endcase
    endfunction

    task automatic push(int c, int k, int v);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(int k, int v);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: got %s(%0d) at cycle %0d, required no event", kname(k), v, cyc);
        end else begin
            e = exp_q.pop_front();
            if ((e.kind != k) || (e.val != v) || (e.cyc != cyc)) begin
                n_bad++;
                $display("FAIL event: got %s(%0d) at cycle %0d, required %s(%0d) at cycle %0d",
                         kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    task automatic check(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: turn DUT outputs into events and compare against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!busy && busy_prev) observe(K_BF, 0);
            if (busy && !busy_prev) observe(K_BR, 0);
            if (load_start)         observe(K_LS, 0);
            if (core_init)          observe(K_CI, 0);
            if (round_en) begin
                observe(K_RD, int'(round_idx));
            end else begin
                n_cmp++;
                if (round_idx != 6'd0) begin
                    n_bad++;
                    $display("FAIL idle_round_idx: got %0d, required 0 (cycle %0d)", round_idx, cyc);
                end
            end
            if (out_valid)          observe(K_OV, 0);
            if (err && !err_prev)   observe(K_ER, 0);
            if (!err && err_prev)   observe(K_EF, 0);
            busy_prev = busy;
            err_prev  = err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(int t);
        while (cyc < t) tick();
    endtask

    // Expected start of every block: busy rises and load_start pulses the
    // cycle after req is seen in IDLE; a pending err clears at the same time.
    task automatic expect_start(int n);
        push(n + 1, K_BR, 0);
        push(n + 1, K_LS, 0);
        if (err_exp) push(n + 1, K_EF, 0);
        err_exp = 1'b0;
    endtask

    // One block starting now (DUT in IDLE). d: cycles from load_start to
    // load_done; dw: done width; w: cycles out_ready stays low in DONE.
    // kill: 0 normal, 1 abort in WAIT_LOAD, 2 abort at round k,
    // 3 abort in DONE, 4 reset+abort+out_ready+req in DONE.
    // Returns at the first IDLE cycle after the block.
    task automatic run_block(input bit hold, input int d, input int dw, input int w,
                             input int kill, input int k, input int id);
        int n;
        int m;
        int d0;
        int e;
        n  = cyc;
        m  = n + 1 + d;
        d0 = m + 2 + ROUNDS;
        expect_start(n);
        if (kill == 1) begin
            e = m + 1;
        end else begin
            push(m + 1, K_CI, 0);
            for (int i = 0; i < ROUNDS; i++) begin
                if ((kill != 2) || (i <= k)) push(m + 2 + i, K_RD, i);
            end
            if (kill == 2) begin
                e = m + 3 + k;
            end else begin
                for (int i = 0; i <= w; i++) push(d0 + i, K_OV, 0);
                e = d0 + w + 1;
            end
        end
        push(e, K_BF, 0);
        $display("block %0d: start=%0d hold=%0d d=%0d dw=%0d w=%0d kill=%0d k=%0d end=%0d",
                 id, n, hold, d, dw, w, kill, k, e);

        req = 1'b1;
        goto(n + 1);
        if (!hold) req = 1'b0;
        goto(m);
        if (kill == 1) begin
            abort = 1'b1;
        end else begin
            load_done = 1'b1;
            goto(m + 1);
            if (dw == 1) load_done = 1'b0;
            goto(m + 2);
            load_done = 1'b0;
            if (kill == 2) begin
                goto(m + 2 + k);
                abort = 1'b1;
            end else begin
                goto(d0 + w);
                case (kill)
                    0: out_ready = 1'b1;
                    3: begin
                        abort     = 1'b1;
                        out_ready = 1'($urandom_range(0, 1));
                    end
                    default: begin
                        reset     = 1'b1;
                        abort     = 1'b1;
                        out_ready = 1'b1;
                        req       = 1'b1;
                    end
                endcase
            end
        end
        goto(e);
        abort     = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b0;
        load_done = 1'b0;
    endtask

    // Between blocks: chain keeps/raises req so the next block starts at once;
    // otherwise idle for gap cycles with ignored noise on the other inputs.
    task automatic between(input bit chain, input int gap);
        if (chain) begin
            req = 1'b1;
        end else begin
            req = 1'b0;
            for (int i = 0; i < gap; i++) begin
                load_done = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                abort     = 1'($urandom_range(0, 1));
                tick();
            end
            load_done = 1'b0;
            out_ready = 1'b0;
            abort     = 1'b0;
        end
    endtask

    // WAIT_LOAD with no load_done for 40 cycles, then an abort.
    task automatic timeout_case();
        int n;
        n = cyc;
        expect_start(n);
`ifdef CTRL_TIMEOUT_EN
        push(n + 2 + LOAD_TIMEOUT, K_BF, 0);
        push(n + 2 + LOAD_TIMEOUT, K_ER, 0);
        err_exp = 1'b1;
`endif
        $display("block timeout: start=%0d", n);
        req = 1'b1;
        goto(n + 1);
        req = 1'b0;
        goto(n + 41);
`ifdef CTRL_TIMEOUT_EN
        check("timeout_busy", int'(busy), 0);
        check("timeout_err", int'(err), 1);
`else
        check("timeout_busy", int'(busy), 1);
        check("timeout_err", int'(err), 0);
        push(n + 42, K_BF, 0);
`endif
        abort = 1'b1;
        goto(n + 42);
        abort = 1'b0;
    endtask

    initial begin
        int kill;
        reset = 1'b1;
        repeat (3) tick();
        check("reset_state",
              int'({load_start, core_init, round_en, busy, out_valid, err, round_idx}), 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Nominal block: done 10 cycles after load_start, held 2 cycles.
        run_block(1'b0, 10, 2, 0, 0, 0, 0);
        between(1'b0, 2);
        // Result held for 20 cycles before acceptance.
        run_block(1'b0, 4, 1, 20, 0, 0, 1);
        between(1'b0, 1);
        // Abort at round 15, then a full block.
        run_block(1'b0, 3, 1, 0, 2, 15, 2);
        between(1'b0, 1);
        run_block(1'b0, 5, 2, 1, 0, 0, 3);
        between(1'b0, 2);
        // Reset in DONE with out_ready and abort high.
        run_block(1'b0, 2, 1, 3, 4, 0, 4);
        between(1'b0, 3);
        // Watchdog behaviour.
        timeout_case();
        between(1'b0, 2);
        // Reset in DONE followed by req in the first cycle after reset.
        run_block(1'b0, 1, 1, 0, 4, 0, 5);
        between(1'b1, 0);
        // req held high: back-to-back blocks.
        for (int b = 0; b < 3; b++) begin
            run_block(1'b1, 1 + b, 2, b, 0, 0, 6 + b);
            between(b != 2, 2);
        end
        // Randomised blocks.
        for (int b = 0; b < 24; b++) begin
            case ($urandom_range(0, 7))
                4:       kill = 1;
                5:       kill = 2;
                6:       kill = 3;
                7:       kill = 4;
                default: kill = 0;
            endcase
            run_block(1'($urandom_range(0, 1)), $urandom_range(1, 12), $urandom_range(1, 2),
                      ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4),
                      kill, $urandom_range(0, ROUNDS - 1), 9 + b);
            between($urandom_range(0, 2) == 0, $urandom_range(1, 3));
        end

        req = 1'b0;
        goto(cyc + 6);
        check("pending_events", exp_q.size(), 0);
        check("final_busy", int'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cipher_seq_ctrl.md
CIPHER_SEQ_CTRL -- requirements
Module: cipher_seq_ctrl

Interface
REQ-001 Parameter ROUNDS, default 32, number of cipher rounds per block (legal 2..63).
REQ-002 Parameter LOAD_TIMEOUT, default 31, maximum WAIT_LOAD cycles before abort (legal 1..255; used only with CTRL_TIMEOUT_EN).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  host request to process one block; level, sampled each cycle.
REQ-006 abort  input  1  synchronous abort of any operation in progress.
REQ-007 load_done  input  1  input-capture unit done flag; held high 1 or 2 consecutive cycles.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 load_start  output  1  one-cycle start pulse to the input-capture unit.
REQ-010 core_init  output  1  one-cycle pulse: core loads 32-bit data and 64-bit key.
REQ-011 round_en  output  1  core executes one round this cycle.
REQ-012 round_idx  output  6  index of the round executing this cycle.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 out_valid  output  1  result valid; held until accepted.
REQ-015 err  output  1  sticky load-timeout flag.

Function
REQ-016 The block SHALL be a Moore FSM: all outputs decoded from registered state/counters, no combinational input-to-output path.
REQ-017 States: IDLE, LOAD_REQ, WAIT_LOAD, INIT, RUN, DONE.
REQ-018 IDLE: req=1 -> LOAD_REQ; otherwise stay.
REQ-019 LOAD_REQ: load_start=1 for exactly this cycle; always -> WAIT_LOAD.
REQ-020 WAIT_LOAD: load_done=1 -> INIT; otherwise stay; load_done samples in any other state SHALL be ignored, so a 2-cycle done pulse causes one transition only.
REQ-021 INIT: core_init=1 for exactly one cycle; round counter cleared to 0; -> RUN.
REQ-022 RUN: round_en=1 and round_idx=counter every cycle; counter increments by 1; when counter=ROUNDS-1 -> DONE; RUN lasts exactly ROUNDS cycles.
REQ-023 DONE: out_valid=1; out_valid&out_ready -> IDLE; otherwise stay; round_en=0.
REQ-024 round_idx SHALL read 0 outside RUN; counter never exceeds ROUNDS-1.
REQ-025 Latency: req seen in IDLE at cycle N -> load_start at N+1; load_done at cycle M in WAIT_LOAD -> core_init at M+1, first round_en at M+2, out_valid at M+2+ROUNDS.
REQ-026 req outside IDLE SHALL be ignored (not queued); req still high in IDLE the cycle after handshake starts a new block.
REQ-027 abort=1 in any state SHALL force IDLE next cycle, clearing counter, round_en, out_valid; abort has priority over every other transition including the DONE handshake.
REQ-028 err SHALL clear on the cycle LOAD_REQ is entered.

Reset
REQ-029 reset=1 SHALL force IDLE, counter 0, and all outputs 0 on the next edge, overriding abort and all inputs, including mid-RUN or mid-DONE.
REQ-030 In the first cycle after reset deasserts, req=1 SHALL be honoured normally.

Configuration
REQ-031 Macro CTRL_TIMEOUT_EN defined: an 8-bit watchdog counts WAIT_LOAD cycles; reaching LOAD_TIMEOUT without load_done SHALL -> IDLE and set err=1; load_done on the timeout cycle wins (-> INIT, err unchanged).
REQ-032 Macro CTRL_TIMEOUT_EN undefined: no watchdog logic; WAIT_LOAD waits indefinitely; err tied to 0.

Structure
REQ-033 Package cipher_seq_pkg SHALL hold the state enumeration, default ROUNDS=32, LOAD_TIMEOUT=31, and round-index width 6.
REQ-034 The watchdog SHALL be sub-module cipher_seq_wdog (clear, enable, terminal-count output), instantiated only under CTRL_TIMEOUT_EN; round counter stays inline.

Verification
REQ-035 ROUNDS=32: req pulse, load_done high 2 cycles 10 cycles after load_start, out_ready=1 -> one core_init, exactly 32 round_en with round_idx 0..31, out_valid 1 cycle, busy low after.
REQ-036 out_ready held 0 for 20 cycles in DONE -> out_valid stays 1, round_en 0, then one-cycle handshake -> IDLE.
REQ-037 abort at round_idx=15 -> next cycle IDLE, round_en=0, round_idx=0, no out_valid; subsequent req runs full 32 rounds.
REQ-038 reset asserted in DONE with out_ready=1 and abort=1 -> all outputs 0 next cycle, no extra load_start.
REQ-039 CTRL_TIMEOUT_EN, LOAD_TIMEOUT=31, load_done never asserted -> IDLE after 31 WAIT_LOAD cycles, err=1 until next LOAD_REQ; without macro same stimulus -> busy stays 1, err 0.
REQ-040 req held high continuously -> back-to-back blocks, load_start exactly once per block, one IDLE cycle between handshake and next LOAD_REQ.
